// File: rtl/rtc_bcd_alarm.sv
// BCD hh:mm:ss real-time clock with a generic tick divider, run/hold, validated time set,
// runtime 12/24-hour display and a maskable hh:mm alarm with a fixed-length fire pulse.
module rtc_bcd_alarm #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int ALARM_LEN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [7:0] set_hr,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic       set_err,
  input  logic       alm_wr,
  input  logic [7:0] alm_hr,
  input  logic [7:0] alm_min,
  input  logic       alm_en,
  output logic       alarm_fire,
  output logic       sec_tick,
  output logic [3:0] hrm,
  output logic [3:0] hrl,
  output logic [3:0] minm,
  output logic [3:0] minl,
  output logic [3:0] secm,
  output logic [3:0] secl,
  output logic       pm
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam int FW = $clog2(ALARM_LEN + 1);
  localparam logic [FW-1:0] FIRE_LEN = FW'(ALARM_LEN);

  typedef struct packed {
    logic [3:0] hm, hl, mm, ml, sm, sl;
  } time_t;

  // With both nibbles <= 9, hex ordering matches decimal ordering.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  time_t         time_q, time_d, time_inc;
  logic [15:0]   alm_q, alm_d;
  logic [FW-1:0] fire_q, fire_d;
  logic          set_err_q;
  logic          set_load, set_bad, tick, alm_match;
  logic [4:0]    hr_bin, hr_12;

  assign set_load  = set_valid && bcd_ok(set_hr, 8'h23) && bcd_ok(set_min, 8'h59)
                     && bcd_ok(set_sec, 8'h59);
  assign set_bad   = set_valid && !set_load;
  assign tick      = !rst && run && (cnt_q == CNT_MAX) && !set_load;
  assign alm_match = tick && alm_en && ({time_inc.sm, time_inc.sl} == 8'h00)
                     && ({time_inc.hm, time_inc.hl, time_inc.mm, time_inc.ml} == alm_q);

  // Seconds-advance cascade; hour wraps 23 -> 00 so no illegal digit is reachable.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    time_inc = time_q;
    if (time_q.sl != 4'd9) time_inc.sl = time_q.sl + 4'd1;
    else begin
      time_inc.sl = 4'd0;
      if (time_q.sm != 4'd5) time_inc.sm = time_q.sm + 4'd1;
      else begin
        time_inc.sm = 4'd0;
        if (time_q.ml != 4'd9) time_inc.ml = time_q.ml + 4'd1;
        else begin
          time_inc.ml = 4'd0;
          if (time_q.mm != 4'd5) time_inc.mm = time_q.mm + 4'd1;
          else begin
            time_inc.mm = 4'd0;
            if ({time_q.hm, time_q.hl} == 8'h23) begin
              time_inc.hm = 4'd0;
              time_inc.hl = 4'd0;
            end else if (time_q.hl == 4'd9) begin
              time_inc.hl = 4'd0;
              time_inc.hm = time_q.hm + 4'd1;
            end else begin
              time_inc.hl = time_q.hl + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    time_d = time_q;
    alm_d  = alm_q;
    fire_d = fire_q;
    if (set_load) begin
      cnt_d  = '0;
      time_d = time_t'({set_hr, set_min, set_sec});
    end else if (run) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
      if (tick) time_d = time_inc;
    end
    if (alm_wr && bcd_ok(alm_hr, 8'h23) && bcd_ok(alm_min, 8'h59)) alm_d = {alm_hr, alm_min};
    if (!alm_en)              fire_d = '0;
    else if (alm_match)       fire_d = FIRE_LEN;
    else if (fire_q != '0)    fire_d = fire_q - FW'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      cnt_q     <= '0;
      time_q    <= '0;
      alm_q     <= '0;
      fire_q    <= '0;
      set_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      time_q    <= time_d;
      alm_q     <= alm_d;
      fire_q    <= fire_d;
      set_err_q <= set_bad;
    end
  end

  // 12h view is derived from the 24h state; hour 0 shows as 12 AM.
  always_comb begin
    hr_bin = {1'b0, time_q.hm} * 5'd10 + {1'b0, time_q.hl};
    hr_12  = hr_bin;
    if (hr_bin == 5'd0)       hr_12 = 5'd12;
    else if (hr_bin > 5'd12)  hr_12 = hr_bin - 5'd12;
    hrm = time_q.hm;
    hrl = time_q.hl;
    pm  = 1'b0;
    if (mode_12h) begin
      pm  = (hr_bin >= 5'd12);
      hrm = (hr_12 >= 5'd10) ? 4'd1 : 4'd0;
      hrl = (hr_12 >= 5'd10) ? 4'(hr_12 - 5'd10) : hr_12[3:0];
    end
  end

  assign minm       = time_q.mm;
  assign minl       = time_q.ml;
  assign secm       = time_q.sm;
  assign secl       = time_q.sl;
  assign sec_tick   = tick;
  assign set_err    = set_err_q;
  assign alarm_fire = (fire_q != '0) && alm_en;

endmodule

// File: tb/tb_rtc_bcd_alarm.sv
// Self-checking bench for rtc_bcd_alarm: directed scenarios plus randomized traffic,
// compared against a seconds-of-day reference model.
module tb_rtc_bcd_alarm;

  localparam int TD = 4;
  localparam int AL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1, run = 1'b0, mode_12h = 1'b0, set_valid = 1'b0;
  logic [7:0] set_hr = '0, set_min = '0, set_sec = '0;
  logic       alm_wr = 1'b0, alm_en = 1'b0;
  logic [7:0] alm_hr = '0, alm_min = '0;
  logic       set_err, alarm_fire, sec_tick, pm;
  logic [3:0] hrm, hrl, minm, minl, secm, secl;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds of day, alarm as minute of day.
  int m_time = 0, m_cnt = 0, m_alarm = 0, m_fire = 0;
  bit m_err = 1'b0;

  logic [24:0] disp_act;
  logic [2:0]  status_act;
  assign disp_act   = {hrm, hrl, minm, minl, secm, secl, pm};
  assign status_act = {sec_tick, alarm_fire, set_err};

  rtc_bcd_alarm #(.TICK_DIV(TD), .ALARM_LEN(AL)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
    .set_err(set_err), .alm_wr(alm_wr), .alm_hr(alm_hr), .alm_min(alm_min),
    .alm_en(alm_en), .alarm_fire(alarm_fire), .sec_tick(sec_tick),
    .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl), .secm(secm), .secl(secl), .pm(pm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int bval(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b, input int maxv);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bval(b) <= maxv);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit set_ok();
    return set_valid && bcd_ok(set_hr, 23) && bcd_ok(set_min, 59) && bcd_ok(set_sec, 59);
  endfunction

  function automatic logic [24:0] disp_exp();
    int h, dh, mi, s;
    bit p;
    h  = m_time / 3600;
    mi = (m_time / 60) % 60;
    s  = m_time % 60;
    dh = h;
    p  = 1'b0;
    if (mode_12h) begin
      p  = (h >= 12);
      dh = (h % 12 == 0) ? 12 : h % 12;
    end
    return {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10), p};
  endfunction

  function automatic logic [2:0] status_exp();
    bit tk;
    tk = !rst && run && (m_cnt == TD - 1) && !set_ok();
    return {tk, (m_fire != 0) && alm_en, m_err};
  endfunction

  task automatic model_edge();
    bit tk;
    int nt;
    if (rst) begin
      m_time = 0; m_cnt = 0; m_alarm = 0; m_fire = 0; m_err = 1'b0;
      return;
    end
    tk    = run && (m_cnt == TD - 1) && !set_ok();
    m_err = set_valid && !set_ok();
    nt    = m_time;
    if (set_ok()) begin
      nt    = bval(set_hr) * 3600 + bval(set_min) * 60 + bval(set_sec);
      m_cnt = 0;
    end else if (run) begin
      if (m_cnt == TD - 1) begin
        m_cnt = 0;
        nt    = (m_time + 1) % 86400;
      end else begin
        m_cnt++;
      end
    end
    if (!alm_en)                                        m_fire = 0;
    else if (tk && nt % 60 == 0 && nt / 60 == m_alarm)  m_fire = AL;
    else if (m_fire > 0)                                m_fire--;
    if (alm_wr && bcd_ok(alm_hr, 23) && bcd_ok(alm_min, 59))
      m_alarm = bval(alm_hr) * 60 + bval(alm_min);
    m_time = nt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    set_hr = h; set_min = mi; set_sec = s; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (disp_act !== 25'h0) begin
      errors++; $display("FAIL reset_disp24: got %h want %h", disp_act, 25'h0);
    end
    checks++;
    if (status_act !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b want 000", status_act);
    end
    mode_12h = 1'b1;
    #1;
    checks++;
    if (disp_act !== {4'h1, 4'h2, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL reset_disp12: got %h want %h", disp_act, {4'h1, 4'h2, 16'h0000, 1'b0});
    end
    mode_12h = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_count();
    run = 1'b1;
    for (int i = 0; i < 40 * TD; i++) begin
      #1;
      checks++;
      if (status_act !== status_exp()) begin
        errors++; $display("FAIL count_status cyc %0d: got %b want %b", i, status_act, status_exp());
      end
      checks++;
      if (disp_act !== disp_exp()) begin
        errors++; $display("FAIL count_disp cyc %0d: got %h want %h", i, disp_act, disp_exp());
      end
      step();
      if (i == 2 || i == 3) begin
        checks++;
        if (secl !== ((i == 3) ? 4'd1 : 4'd0)) begin
          errors++; $display("FAIL count_first_sec edge %0d: got %0d", i + 1, secl);
        end
      end
    end
    #1;
    checks++;
    if (disp_act !== {20'h00004, 4'h0, 1'b0}) begin
      errors++; $display("FAIL count_40s: got %h want %h", disp_act, {20'h00004, 4'h0, 1'b0});
    end
  endtask

  task automatic test_wrap();
    set_time(8'h23, 8'h59, 8'h58);
    for (int k = 0; k < 2 * TD; k++) begin
      #1;
      checks++;
      if (disp_act !== disp_exp() || status_act !== status_exp()) begin
        errors++; $display("FAIL wrap_model cyc %0d: got %h/%b want %h/%b",
                           k, disp_act, status_act, disp_exp(), status_exp());
      end
      step();
      if (k == TD - 1) begin
        checks++;
        if (disp_act !== {24'h235959, 1'b0}) begin
          errors++; $display("FAIL wrap_235959: got %h", disp_act);
        end
      end
    end
    #1;
    checks++;
    if (disp_act !== 25'h0) begin
      errors++; $display("FAIL wrap_midnight: got %h want 0", disp_act);
    end
    mode_12h = 1'b1;
    #1;
    checks++;
    if (disp_act !== {24'h120000, 1'b0}) begin
      errors++; $display("FAIL wrap_midnight12: got %h", disp_act);
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_12h();
    mode_12h = 1'b1;
    set_time(8'h13, 8'h05, 8'h00);
    #1;
    checks++;
    if (disp_act !== {24'h010500, 1'b1}) begin
      errors++; $display("FAIL h12_1305: got %h want %h", disp_act, {24'h010500, 1'b1});
    end
    set_time(8'h12, 8'h00, 8'h00);
    #1;
    checks++;
    if (disp_act !== {24'h120000, 1'b1}) begin
      errors++; $display("FAIL h12_noon: got %h want %h", disp_act, {24'h120000, 1'b1});
    end
    for (int h = 0; h < 24; h++) begin
      set_time(to_bcd(h), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59)));
      mode_12h = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (disp_act !== disp_exp()) begin
        errors++; $display("FAIL h12_sweep h=%0d mode=%0b: got %h want %h", h, mode_12h, disp_act, disp_exp());
      end
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_set_err();
    set_time(8'h10, 8'h20, 8'h30);
    set_hr = 8'h24; set_min = 8'h00; set_sec = 8'h00; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    #1;
    checks++;
    if (set_err !== 1'b1 || disp_act !== {24'h102030, 1'b0}) begin
      errors++; $display("FAIL err_hr24: got err=%b disp=%h want err=1 disp=%h", set_err, disp_act, {24'h102030, 1'b0});
    end
    step();
    set_hr = 8'h10; set_min = 8'h20; set_sec = 8'h5A; set_valid = 1'b1;
    #1;
    checks++;
    if (set_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse_len: got %b want 0", set_err);
    end
    step();
    set_valid = 1'b0;
    #1;
    checks++;
    if (set_err !== 1'b1 || disp_act !== {24'h102030, 1'b0}) begin
      errors++; $display("FAIL err_sec5a: got err=%b disp=%h", set_err, disp_act);
    end
    for (int k = 0; k < 2 * TD && m_cnt != TD - 1; k++) step();
    set_hr = 8'h08; set_min = 8'h15; set_sec = 8'h45; set_valid = 1'b1;
    #1;
    checks++;
    if (sec_tick !== 1'b0 || status_act !== status_exp()) begin
      errors++; $display("FAIL set_on_tick_pulse: got %b want %b", status_act, status_exp());
    end
    step();
    set_valid = 1'b0;
    #1;
    checks++;
    if (disp_act !== {24'h081545, 1'b0}) begin
      errors++; $display("FAIL set_on_tick_time: got %h want %h", disp_act, {24'h081545, 1'b0});
    end
    for (int j = 0; j < TD; j++) begin
      checks++;
      if (sec_tick !== (j == TD - 1)) begin
        errors++; $display("FAIL set_cnt_cleared cyc %0d: got %b", j, sec_tick);
      end
      step();
      #1;
    end
  endtask

  task automatic test_alarm();
    alm_en = 1'b1;
    alm_hr = 8'h07; alm_min = 8'h30; alm_wr = 1'b1;
    step();
    alm_hr = 8'h25; alm_min = 8'h61;
    step();
    alm_wr = 1'b0;
    for (int pass = 0; pass < 3; pass++) begin
      alm_en = (pass != 1);
      if (pass == 2) set_time(8'h07, 8'h30, 8'h00);
      else           set_time(8'h07, 8'h29, 8'h59);
      for (int k = 0; k < 9; k++) begin
        #1;
        checks++;
        if (alarm_fire !== (pass == 0 && k >= TD && k < TD + AL)) begin
          errors++; $display("FAIL alarm_pass%0d cyc %0d: got %b", pass, k, alarm_fire);
        end
        checks++;
        if (status_act !== status_exp()) begin
          errors++; $display("FAIL alarm_model pass%0d cyc %0d: got %b want %b", pass, k, status_act, status_exp());
        end
        step();
      end
    end
    alm_en = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    for (int k = 0; k < TD; k++) step();
    #1;
    checks++;
    if (alarm_fire !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got %b want 1", alarm_fire);
    end
    alm_en = 1'b0;
    #1;
    checks++;
    if (alarm_fire !== 1'b0) begin
      errors++; $display("FAIL abort_now: got %b want 0", alarm_fire);
    end
    step();
    alm_en = 1'b1;
    #1;
    checks++;
    if (alarm_fire !== 1'b0) begin
      errors++; $display("FAIL abort_cleared: got %b want 0", alarm_fire);
    end
  endtask

  task automatic test_hold();
    logic [24:0] held;
    set_time(8'h11, 8'h22, 8'h33);
    step();
    step();
    run  = 1'b0;
    held = disp_exp();
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (disp_act !== held || sec_tick !== 1'b0) begin
        errors++; $display("FAIL hold_frozen cyc %0d: got %h tick %b want %h tick 0", k, disp_act, sec_tick, held);
      end
      step();
    end
    run = 1'b1;
    for (int j = 0; j < TD; j++) begin
      #1;
      checks++;
      if (sec_tick !== (j == 1)) begin
        errors++; $display("FAIL hold_resume cyc %0d: got %b want %b", j, sec_tick, (j == 1));
      end
      step();
    end
  endtask

  task automatic test_reset_mid_alarm();
    bit seen;
    alm_en = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    seen = 1'b0;
    for (int k = 0; k < 3 * TD && !seen; k++) begin
      step();
      #1;
      seen = alarm_fire;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_mid_setup: got no alarm_fire within %0d cycles", 3 * TD);
    end
    rst = 1'b1;
    step();
    #1;
    checks++;
    if (disp_act !== 25'h0 || status_act !== 3'b000) begin
      errors++; $display("FAIL rst_mid_alarm: got %h/%b want 0/000", disp_act, status_act);
    end
    rst = 1'b0;
    set_time(8'h23, 8'h59, 8'h59);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (alarm_fire !== (k >= TD && k < TD + AL)) begin
        errors++; $display("FAIL rst_alarm_0000 cyc %0d: got %b", k, alarm_fire);
      end
      step();
    end
  endtask

  task automatic test_random();
    int nxt;
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      run       = ($urandom_range(0, 7) != 0);
      mode_12h  = 1'($urandom_range(0, 1));
      alm_en    = ($urandom_range(0, 29) != 0);
      set_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) begin
        set_hr = 8'($urandom); set_min = 8'($urandom); set_sec = 8'($urandom);
      end else begin
        set_hr  = to_bcd($urandom_range(0, 23));
        set_min = to_bcd($urandom_range(0, 59));
        set_sec = to_bcd($urandom_range(55, 59));
      end
      alm_wr  = ($urandom_range(0, 19) == 0);
      nxt     = (m_time / 60 + 1) % 1440;
      alm_hr  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : to_bcd(nxt / 60);
      alm_min = to_bcd(nxt % 60);
      #1;
      checks++;
      if (status_act !== status_exp()) begin
        errors++; $display("FAIL rand_status cyc %0d: got %b want %b", i, status_act, status_exp());
      end
      checks++;
      if (disp_act !== disp_exp()) begin
        errors++; $display("FAIL rand_disp cyc %0d: got %h want %h", i, disp_act, disp_exp());
      end
      step();
    end
    rst = 1'b0; set_valid = 1'b0; alm_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_12h();
    test_set_err();
    test_alarm();
    test_hold();
    test_reset_mid_alarm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
